// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU command issuer.
//   OP_*     : 2-bit ALU opcodes.
//   ALU_WIDTH: default operand/result width.
//   state_t  : issuer FSM states.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    localparam logic [1:0] OP_OFF   = 2'd0;
    localparam logic [1:0] OP_ADD   = 2'd1;
    localparam logic [1:0] OP_SUB   = 2'd2;
    localparam logic [1:0] OP_NO_OP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO holding packed {a, b, op} commands.
//   clk, rst   : clock, synchronous active-low reset
//   push, data : write request and entry (caller guarantees not full)
//   pop        : read request (caller guarantees not empty)
//   head       : entry at the read pointer (combinational)
//   count      : registered occupancy
module cmd_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands and issues them one at a time to an
// external 4-bit ALU, returning each result with a sequence tag.
//   clk, rst                       : clock, synchronous active-low reset
//   cmd_valid/ready, cmd_a/b/op    : command input handshake
//   alu_a/b/op                     : registered drive to the ALU
//   alu_out, alu_flag              : ALU result inputs
//   rsp_valid/ready, rsp_out/flag/tag : response output handshake
//   busy                           : FSM not idle
//   fifo_count                     : queued command count
// The ALU's own active-high reset is expected to be driven from ~rst.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int DEPTH      = 4,
    parameter int RESULT_LAT = 1,
    parameter int TAG_W      = 4,
    parameter int CW         = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_flag,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [CW-1:0]    fifo_count
);

    localparam int EW = 2 * WIDTH + 2;
    localparam int LW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

    state_t           state;
    logic [LW-1:0]    wait_cnt;
    logic [TAG_W-1:0] tag_cnt;
    logic             push;
    logic             pop;
    logic [EW-1:0]    head;

    // Readiness comes from the registered count only, so a pop in the same
    // cycle never opens room for a push.
    assign cmd_ready = rst && (fifo_count < CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;

    // Dequeue when idle, or when the pending response is consumed so the
    // next command skips the IDLE cycle.
    assign pop = (fifo_count != '0) &&
                 ((state == ST_IDLE) || (state == ST_RESP && rsp_ready));

    assign busy = (state != ST_IDLE);

    cmd_fifo #(.W(EW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .data  ({cmd_a, cmd_b, cmd_op}),
        .pop   (pop),
        .head  (head),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            tag_cnt   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= OP_OFF;   // clears the ALU output
            rsp_valid <= 1'b0;
            rsp_out   <= '0;
            rsp_flag  <= 1'b0;
            rsp_tag   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    alu_op <= OP_NO_OP;
                    if (pop) begin
                        {alu_a, alu_b, alu_op} <= head;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // ALU samples the command at this edge; NO_OP afterwards
                    // keeps its result stable until captured.
                    alu_op   <= OP_NO_OP;
                    wait_cnt <= LW'(RESULT_LAT - 1);
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_out   <= alu_out;
                        rsp_flag  <= alu_flag;
                        rsp_tag   <= tag_cnt;
                        tag_cnt   <= tag_cnt + 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (pop) begin
                            {alu_a, alu_b, alu_op} <= head;
                            state <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
